// File: rtl/fp_acc_pkg.sv
// Shared state encoding and binary32 constants for the streaming accumulator.
package fp_acc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [31:0] FP_POS_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP_POS_INF  = 32'h7F80_0000;
  localparam logic [31:0] FP_MAX_POS  = 32'h7F7F_FFFF;
  localparam logic [31:0] FP_MAX_NEG  = 32'hFF7F_FFFF;
  localparam logic [31:0] FP_QNAN     = 32'h7FC0_0000;

endpackage

// File: rtl/fp_accumulator_if.sv
// Operand stream in, frame result out; master drives operands and result-ready.
interface fp_accumulator_if #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 16
);
  logic [WIDTH-1:0]     in_data;
  logic                 in_valid;
  logic                 in_last;
  logic                 in_ready;
  logic [WIDTH-1:0]     out_data;
  logic [CNT_WIDTH-1:0] out_count;
  logic                 out_overflow;
  logic                 out_valid;
  logic                 out_ready;

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_count, out_overflow, out_valid
  );

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_count, out_overflow, out_valid
  );
endinterface

// File: rtl/fp_accumulator_adder.sv
// Combinational binary32 adder (round-to-nearest-even); overflow flags a finite sum rounding to inf.
// Zero latency, no handshake.
module floatingPointAdder
  import fp_acc_pkg::*;
(
  input  logic [31:0] x,
  input  logic [31:0] y,
  output logic [31:0] result,
  output logic        overflow
);
  logic [31:0] a, b;
  logic [7:0]  ea, eb, d;
  logic [26:0] al, bl, bfull, mask, n;
  logic [27:0] sum;
  logic [9:0]  e, s;
  logic [4:0]  lz;
  logic [24:0] r;
  logic [23:0] mant;
  logic        rnd;

  always_comb begin
    // a always holds the larger magnitude, so any NaN/inf operand lands in a
    a     = (x[30:0] >= y[30:0]) ? x : y;
    b     = (x[30:0] >= y[30:0]) ? y : x;
    ea    = (a[30:23] == 8'd0) ? 8'd1 : a[30:23];
    eb    = (b[30:23] == 8'd0) ? 8'd1 : b[30:23];
    d     = ea - eb;
    al    = {a[30:23] != 8'd0, a[22:0], 3'b000};
    bfull = {b[30:23] != 8'd0, b[22:0], 3'b000};
    mask  = (27'd1 << d) - 27'd1;
    bl    = (d >= 8'd27) ? {26'd0, |bfull}
                         : ((bfull >> d) | {26'd0, |(bfull & mask)});
    sum   = (a[31] == b[31]) ? ({1'b0, al} + {1'b0, bl}) : ({1'b0, al} - {1'b0, bl});
    lz    = 5'd27;
    for (int i = 0; i < 27; i++) begin
      if (sum[i]) lz = 5'(26 - i);
    end
    e = {2'b00, ea};
    s = 10'd0;
    if (sum[27]) begin
      n = {sum[27:2], sum[1] | sum[0]};
      e = e + 10'd1;
    end else begin
      s = ({5'd0, lz} < e) ? {5'd0, lz} : (e - 10'd1);
      n = sum[26:0] << s;
      e = e - s;
    end
    rnd  = n[2] & (n[1] | n[0] | n[3]);
    r    = {1'b0, n[26:3]} + {24'd0, rnd};
    mant = r[24] ? r[24:1] : r[23:0];
    if (r[24]) e = e + 10'd1;

    overflow = 1'b0;
    if (a[30:23] == 8'hFF) begin
      if (a[22:0] != 23'd0 || (b[30:0] == FP_POS_INF[30:0] && a[31] != b[31]))
        result = FP_QNAN;
      else
        result = a;
    end else if (sum == 28'd0) begin
      result = {a[31] & b[31], 31'd0};
    end else if (e >= 10'd255) begin
      result   = {a[31], FP_POS_INF[30:0]};
      overflow = 1'b1;
    end else begin
      result = {a[31], mant[23] ? e[7:0] : 8'd0, mant[22:0]};
    end
  end
endmodule

// File: rtl/fp_accumulator.sv
// Frame accumulator: one operand/cycle, result valid the cycle after in_last; in_ready low while result waits.
// Optional FP_ACC_SATURATE_EN clamps overflowing adds to +/-max-finite.
module fp_accumulator
  import fp_acc_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 16
) (
  input logic             clk,
  input logic             rst,
  fp_accumulator_if.slave bus
);
  state_t               state;
  logic [WIDTH-1:0]     acc;
  logic [WIDTH-1:0]     add_result;
  logic [WIDTH-1:0]     acc_next;
  logic [CNT_WIDTH-1:0] count;
  logic                 ovf;
  logic                 add_ovf;
  logic                 ready_q;
  logic                 valid_q;
  logic                 accept;

  floatingPointAdder u_adder (
    .x        (acc),
    .y        (bus.in_data),
    .result   (add_result),
    .overflow (add_ovf)
  );

`ifdef FP_ACC_SATURATE_EN
  assign acc_next = add_ovf ? (add_result[WIDTH-1] ? FP_MAX_NEG : FP_MAX_POS) : add_result;
`else
  assign acc_next = add_result;
`endif

  assign accept           = bus.in_valid && ready_q;
  assign bus.in_ready     = ready_q;
  assign bus.out_valid    = valid_q;
  assign bus.out_data     = acc;
  assign bus.out_count    = count;
  assign bus.out_overflow = ovf;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      acc     <= FP_POS_ZERO;
      count   <= '0;
      ovf     <= 1'b0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_ACCUM: begin
          if (accept) begin
            acc   <= acc_next;
            count <= (&count) ? count : count + CNT_WIDTH'(1);
            ovf   <= ovf | add_ovf;
            if (bus.in_last) begin
              state   <= ST_DONE;
              ready_q <= 1'b0;
              valid_q <= 1'b1;
            end else begin
              state <= ST_ACCUM;
            end
          end
        end
        default: begin
          // Result drains; the frame's state clears on the same edge
          if (bus.out_ready) begin
            state   <= ST_IDLE;
            acc     <= FP_POS_ZERO;
            count   <= '0;
            ovf     <= 1'b0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fp_accumulator.sv
// Bench for fp_accumulator: directed frames plus random integer-valued frames against an exact-sum model.
module tb_fp_accumulator;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fp_accumulator_if #(.WIDTH(32), .CNT_WIDTH(16)) bus ();

  fp_accumulator #(.WIDTH(32), .CNT_WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Exact binary32 encoding of a small integer (|v| < 2^24)
  function automatic logic [31:0] int_to_fp(input int v);
    int mag;
    int p;
    logic [31:0] m;
    if (v == 0) return 32'h0;
    mag = (v < 0) ? -v : v;
    p = 0;
    for (int i = 0; i < 24; i++) if (mag >= (1 << i)) p = i;
    m = 32'(mag) << (23 - p);
    return {(v < 0), 8'(127 + p), m[22:0]};
  endfunction

  task automatic push(input logic [31:0] d, input logic last);
    int n = 0;
    bus.in_data  = d;
    bus.in_last  = last;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 100) begin @(posedge clk); #1; n++; end
    check("in_ready_seen", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic get_result(input int hold, output logic [31:0] d, output logic [15:0] c,
                            output logic o);
    int n = 0;
    while (!bus.out_valid && n < 100) begin @(posedge clk); #1; n++; end
    check("out_valid_seen", {31'd0, bus.out_valid}, 32'd1);
    d = bus.out_data;
    c = bus.out_count;
    o = bus.out_overflow;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_data", bus.out_data, d);
      check("hold_in_ready", {31'd0, bus.in_ready}, 32'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("released", {31'd0, bus.out_valid}, 32'd0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
    check({tag, "_out_valid"}, {31'd0, bus.out_valid}, 32'd0);
    check({tag, "_out_data"}, bus.out_data, 32'd0);
    check({tag, "_out_count"}, 32'(bus.out_count), 32'd0);
    check({tag, "_out_ovf"}, {31'd0, bus.out_overflow}, 32'd0);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  logic [31:0] rd;
  logic [15:0] rc;
  logic        ro;
  logic [31:0] exp_ovf_data;
  int          len;
  int          total;
  int          v;
  int          hold;
  bit          early;

  initial begin
    rst = 1'b1;
    bus.in_data = '0; bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_state("reset");

    // 1 + 1, latency and backpressure with next operand already waiting
    push(32'h3F800000, 1'b0);
    push(32'h3F800000, 1'b1);
    check("lat_out_valid", {31'd0, bus.out_valid}, 32'd1);
    bus.in_data = 32'h40400000; bus.in_last = 1'b1; bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
      check("bp_out_data", bus.out_data, 32'h40000000);
      check("bp_out_count", 32'(bus.out_count), 32'd2);
      check("bp_out_ovf", {31'd0, bus.out_overflow}, 32'd0);
      check("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("bp_restart_ready", {31'd0, bus.in_ready}, 32'd1);
    check("bp_restart_valid", {31'd0, bus.out_valid}, 32'd0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.in_last = 1'b0;
    get_result(0, rd, rc, ro);
    check("restart_data", rd, 32'h40400000);
    check("restart_count", 32'(rc), 32'd1);

    // 1 + -1 cancels to +0
    push(32'h3F800000, 1'b0);
    push(32'hBF800000, 1'b1);
    get_result(1, rd, rc, ro);
    check("cancel_data", rd, 32'h00000000);
    check("cancel_count", 32'(rc), 32'd2);
    check("cancel_ovf", {31'd0, ro}, 32'd0);

    // Overflow
`ifdef FP_ACC_SATURATE_EN
    exp_ovf_data = 32'h7F7FFFFF;
`else
    exp_ovf_data = 32'h7F800000;
`endif
    push(32'h7F000000, 1'b0);
    push(32'h7F000000, 1'b1);
    get_result(2, rd, rc, ro);
    check("ovf_data", rd, exp_ovf_data);
    check("ovf_flag", {31'd0, ro}, 32'd1);

    // NaN sticks
    push(32'h7FC00000, 1'b0);
    push(32'h3F800000, 1'b1);
    get_result(0, rd, rc, ro);
    check("nan_data", rd, 32'h7FC00000);
    check("nan_ovf", {31'd0, ro}, 32'd0);

    // Reset after 3 of 5 operands discards the partial frame
    push(32'h3F800000, 1'b0);
    push(32'h40000000, 1'b0);
    push(32'h40400000, 1'b0);
    pulse_reset();
    check_reset_state("midrst");
    push(32'h40400000, 1'b1);
    get_result(0, rd, rc, ro);
    check("midrst_data", rd, 32'h40400000);
    check("midrst_count", 32'(rc), 32'd1);

    // Reset while a result waits
    push(32'h3F800000, 1'b1);
    pulse_reset();
    check_reset_state("donerst");

    // Random integer-valued frames: every partial sum is exact in binary32
    for (int f = 0; f < 40; f++) begin
      len   = int'($urandom_range(6, 1));
      total = 0;
      early = ($urandom_range(3) == 0);
      for (int k = 0; k < len; k++) begin
        v = int'($urandom_range(2000)) - 1000;
        total += v;
        repeat (int'($urandom_range(2))) begin @(posedge clk); #1; end
        if (early && k == len - 1) bus.out_ready = 1'b1;
        push(int_to_fp(v), k == len - 1);
      end
      hold = early ? 0 : int'($urandom_range(3));
      get_result(hold, rd, rc, ro);
      check("rnd_data", rd, int_to_fp(total));
      check("rnd_count", 32'(rc), 32'(len));
      check("rnd_ovf", {31'd0, ro}, 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fp_accumulator.md
# fp_accumulator

Streaming single-precision accumulator sitting directly downstream of the combinational `floatingPointAdder`. It accepts a frame of IEEE-754 binary32 operands over a valid/ready stream and feeds the running sum and each new operand into the adder every cycle. It registers the adder's result back as the new running sum. At frame end it presents the total, an element count and a sticky overflow flag on an output handshake.

## Interface
- `WIDTH`, 32, operand/result width; binary32 only, other values unsupported.
- `CNT_WIDTH`, 16, width of the element counter.
- `clk` input 1: single clock; all state updates on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_data` input WIDTH: operand to add.
- `in_valid` input 1: `in_data`/`in_last` valid.
- `in_last` input 1: marks the final operand of a frame.
- `in_ready` output 1: block can accept an operand this cycle.
- `out_data` output WIDTH: frame sum.
- `out_count` output CNT_WIDTH: operands accepted in the frame; saturates at all-ones.
- `out_overflow` output 1: OR of adder `overflow` over every add in the frame.
- `out_valid` output 1: frame result valid.
- `out_ready` input 1: downstream accepts the result.

## Operation
- States: IDLE (accumulator = +0, nothing accepted), ACCUM (at least one operand accepted, no `in_last` yet), DONE (result held).
- Accept condition: `in_valid && in_ready`.
- `in_ready` = 1 in IDLE and ACCUM, 0 in DONE.
- On accept: `acc <= adder.result(x=acc, y=in_data)`; `count <= count+1` (saturating); `ovf <= ovf | adder.overflow`.
- The first operand of a frame is added to +0 (`0x00000000`), so a single-element frame returns `in_data` as produced by the adder.
- IDLE -> ACCUM on accept with `in_last`=0.
- IDLE or ACCUM -> DONE on accept with `in_last`=1.
- DONE: `out_valid`=1; `out_data`=`acc`, `out_count`=`count`, `out_overflow`=`ovf`, all stable while `out_valid && !out_ready`.
- DONE -> IDLE on `out_ready`. On that edge `acc`, `count` and `ovf` clear.
- `in_valid`=0 in IDLE/ACCUM: hold state, no change.
- Specials propagate as the adder produces them (±inf sticks, NaN sticks); no extra handling beyond the Configuration item.
- `rst` at any time, including mid-frame or while DONE waits: state IDLE, `acc`=0, `count`=0, `ovf`=0, `out_valid`=0, `in_ready`=1 the cycle after reset deasserts. A partial frame is discarded.

## Timing
- Throughput: one operand per cycle within a frame.
- Latency: `out_valid` rises on the cycle after the `in_last` accept.
- Minimum one-cycle input bubble between frames: `in_ready`=0 in DONE. The earliest next accept is the cycle after `out_ready` is sampled high.
- `out_ready` may be high before `out_valid`; the handshake completes on the first DONE cycle.
- Adder is combinational between `acc`/`in_data` and `acc` D-input: one adder delay per cycle is the critical path.
- Reset values: `in_ready`=1 after reset, `out_valid`=0, `out_data`=0, `out_count`=0, `out_overflow`=0.

## Configuration
- `FP_ACC_SATURATE_EN` defined: when an accepted add reports `overflow`=1, `acc` loads ±max-finite instead of the adder result. Sign is taken from the adder result: `0x7F7FFFFF` / `0xFF7FFFFF`. `ovf` still sets.
- Not defined: `acc` loads the adder result unchanged (±inf on overflow).

## Structure
- Shared package `fp_acc_pkg`:
  - state encoding (IDLE/ACCUM/DONE);
  - constants `FP_POS_ZERO`=`0x00000000`, `FP_POS_INF`=`0x7F800000`, `FP_MAX_POS`=`0x7F7FFFFF`, `FP_MAX_NEG`=`0xFF7FFFFF`.
- One sub-module: instance of existing `floatingPointAdder` (ports `x`, `y`, `result`, `overflow`). No new arithmetic is written in this block.

## Test plan
- Frame {`0x3F800000`, `0x3F800000` last} -> `out_data`=`0x40000000`, `out_count`=2, `out_overflow`=0, `out_valid` one cycle after last accept.
- Frame {`0x3F800000`, `0xBF800000` last} -> `out_data`=`0x00000000`, `out_count`=2, `out_overflow`=0.
- Frame {`0x7F000000`, `0x7F000000` last} -> without macro `out_data`=`0x7F800000`, `out_overflow`=1; with `FP_ACC_SATURATE_EN` `out_data`=`0x7F7FFFFF`, `out_overflow`=1.
- Frame {`0x7FC00000`, `0x3F800000` last} -> `out_data`=`0x7FC00000` (NaN sticks), `out_overflow`=0.
- Backpressure: hold `out_ready`=0 for 5 cycles in DONE with `in_valid`=1 -> `in_ready`=0 and outputs stable throughout. Raise `out_ready` -> next frame's first operand accepted the following cycle with `acc` restarted from +0.
- `rst` pulsed after 3 of 5 operands -> IDLE, all outputs at reset values. A fresh single-element frame {`0x40400000` last} then returns `0x40400000`, `out_count`=1.
